// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states and op classification.
package alu_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_REM  = 4'd11;
    localparam logic [3:0] OP_SLT  = 4'd12;
    localparam logic [3:0] OP_SLTU = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // mul/mulh/div/rem need the long hold on the ALU inputs
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REM);
    endfunction

    // opcodes 14 and 15 are not defined for the ALU
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_SLTU;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: purely combinational, history kept by the caller.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Alternate when both request, otherwise pass the lone requester through
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters with a
// single tagged response channel. Optional performance counters are
// enabled with the ALU_ARB_PERF_EN macro.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int XLEN          = XLEN_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            REQ0_VALID,
    output logic            REQ0_READY,
    input  logic [XLEN-1:0] REQ0_X,
    input  logic [XLEN-1:0] REQ0_Y,
    input  logic [3:0]      REQ0_OP,
    input  logic            REQ1_VALID,
    output logic            REQ1_READY,
    input  logic [XLEN-1:0] REQ1_X,
    input  logic [XLEN-1:0] REQ1_Y,
    input  logic [3:0]      REQ1_OP,
    output logic [XLEN-1:0] ALU_X,
    output logic [XLEN-1:0] ALU_Y,
    output logic [3:0]      ALU_OP,
    input  logic [XLEN-1:0] ALU_RESULT,
    input  logic            ALU_EQUAL,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic            RSP_ID,
    output logic [XLEN-1:0] RSP_DATA,
    output logic            RSP_EQ,
    output logic            RSP_ERR
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]     PERF_GRANT0,
    output logic [31:0]     PERF_GRANT1,
    output logic [31:0]     PERF_BUSY
`endif
);

    state_t          state;
    state_t          state_nxt;
    logic            last_grant;
    logic [1:0]      grant;
    logic            accept;
    logic            accept_id;
    logic            capture;
    logic [3:0]      cnt;
    logic [XLEN-1:0] sel_x;
    logic [XLEN-1:0] sel_y;
    logic [3:0]      sel_op;
    logic [3:0]      sel_hold;
    logic [XLEN-1:0] x_q;
    logic [XLEN-1:0] y_q;
    logic [3:0]      op_q;
    logic            id_q;

    // Division corner cases and illegal ops replace whatever the ALU produced
    function automatic logic [XLEN-1:0] fix_result(
        input logic [3:0]      op,
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y,
        input logic [XLEN-1:0] res
    );
        if (is_illegal(op))               return '0;
        if (op == OP_DIV && y == '0)      return '1;
        if (op == OP_REM && y == '0)      return x;
        return res;
    endfunction

    rr_arb2 u_arb (
        .valid      ({REQ1_VALID, REQ0_VALID}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign accept_id = grant[1];
    assign sel_x     = accept_id ? REQ1_X  : REQ0_X;
    assign sel_y     = accept_id ? REQ1_Y  : REQ0_Y;
    assign sel_op    = accept_id ? REQ1_OP : REQ0_OP;
    assign sel_hold  = is_multicycle(sel_op) ? 4'(MULDIV_CYCLES) : 4'd1;

    // The ALU sees only the latched request, so it stays quiet outside EXEC
    assign ALU_X  = x_q;
    assign ALU_Y  = y_q;
    assign ALU_OP = op_q;

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, grant handshake and capture strobe
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        capture    = 1'b0;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        case (state)
            IDLE: begin
                REQ0_READY = grant[0] & ~RESET;
                REQ1_READY = grant[1] & ~RESET;
                if (|grant) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the granted request and its hold time; track round-robin history
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x_q        <= '0;
            y_q        <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            x_q        <= sel_x;
            y_q        <= sel_y;
            op_q       <= sel_op;
            id_q       <= accept_id;
            cnt        <= sel_hold;
            last_grant <= accept_id;
        end else if (state == EXEC && cnt != 4'd1) begin
            cnt        <= cnt - 4'd1;
        end
    end

    // Capture the ALU output and hold the response until it is taken
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RSP_VALID <= 1'b0;
            RSP_ID    <= 1'b0;
            RSP_DATA  <= '0;
            RSP_EQ    <= 1'b0;
            RSP_ERR   <= 1'b0;
        end else if (capture) begin
            RSP_VALID <= 1'b1;
            RSP_ID    <= id_q;
            RSP_DATA  <= fix_result(op_q, x_q, y_q, ALU_RESULT);
            RSP_EQ    <= ALU_EQUAL;
            RSP_ERR   <= is_illegal(op_q);
        end else if (state == RESP && RSP_READY) begin
            RSP_VALID <= 1'b0;
        end
    end

`ifdef ALU_ARB_PERF_EN
    // Free-running grant and busy counters, wrapping at 2^32
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PERF_GRANT0 <= '0;
            PERF_GRANT1 <= '0;
            PERF_BUSY   <= '0;
        end else begin
            if (accept && !accept_id) PERF_GRANT0 <= PERF_GRANT0 + 32'd1;
            if (accept &&  accept_id) PERF_GRANT1 <= PERF_GRANT1 + 32'd1;
            if (state == EXEC)        PERF_BUSY   <= PERF_BUSY + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU beside the DUT.
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
    logic [63:0] REQ0_X, REQ0_Y, REQ1_X, REQ1_Y;
    logic [3:0]  REQ0_OP, REQ1_OP;
    logic [63:0] ALU_X, ALU_Y, ALU_RESULT;
    logic [3:0]  ALU_OP;
    logic        ALU_EQUAL;
    logic        RSP_VALID, RSP_READY, RSP_ID, RSP_EQ, RSP_ERR;
    logic [63:0] RSP_DATA;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] PERF_GRANT0, PERF_GRANT1, PERF_BUSY;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [127:0] prod;

    always #5 CLK = ~CLK;

    alu_arbiter #(.MULDIV_CYCLES(4), .XLEN(64)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
        .REQ0_X(REQ0_X), .REQ0_Y(REQ0_Y), .REQ0_OP(REQ0_OP),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
        .REQ1_X(REQ1_X), .REQ1_Y(REQ1_Y), .REQ1_OP(REQ1_OP),
        .ALU_X(ALU_X), .ALU_Y(ALU_Y), .ALU_OP(ALU_OP),
        .ALU_RESULT(ALU_RESULT), .ALU_EQUAL(ALU_EQUAL),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_DATA(RSP_DATA), .RSP_EQ(RSP_EQ), .RSP_ERR(RSP_ERR)
`ifdef ALU_ARB_PERF_EN
        ,
        .PERF_GRANT0(PERF_GRANT0), .PERF_GRANT1(PERF_GRANT1), .PERF_BUSY(PERF_BUSY)
`endif
    );

    // Behavioural ALU; divide-by-zero and illegal ops return junk the DUT must override
    always_comb begin
        prod = {64'd0, ALU_X} * {64'd0, ALU_Y};
        case (ALU_OP)
            4'd0:    ALU_RESULT = ALU_X + ALU_Y;
            4'd1:    ALU_RESULT = ALU_X - ALU_Y;
            4'd8:    ALU_RESULT = prod[63:0];
            4'd9:    ALU_RESULT = prod[127:64];
            4'd10:   ALU_RESULT = (ALU_Y == 64'd0) ? 64'hDEAD : ALU_X / ALU_Y;
            4'd11:   ALU_RESULT = (ALU_Y == 64'd0) ? 64'hBEEF : ALU_X % ALU_Y;
            default: ALU_RESULT = 64'h0BAD_0BAD;
        endcase
    end
    assign ALU_EQUAL = (ALU_X == ALU_Y);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_op(input logic id, input logic [63:0] x, input logic [63:0] y,
                         input logic [3:0] op, input logic [63:0] exp_data,
                         input logic exp_eq, input logic exp_err, input int exp_lat);
        int n;
        if (id) begin
            REQ1_VALID = 1'b1; REQ1_X = x; REQ1_Y = y; REQ1_OP = op;
        end else begin
            REQ0_VALID = 1'b1; REQ0_X = x; REQ0_Y = y; REQ0_OP = op;
        end
        #1;
        check("ready_own",   id ? REQ1_READY : REQ0_READY, 64'd1);
        check("ready_other", id ? REQ0_READY : REQ1_READY, 64'd0);
        cyc();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        REQ0_X = ~x; REQ1_X = ~x; REQ0_Y = ~y; REQ1_Y = ~y;
        #1;
        n = 1;
        while (!RSP_VALID && n < 24) begin
            check("alu_op_hold", ALU_OP, op);
            check("alu_x_hold", ALU_X, x);
            check("ready_busy", REQ0_READY | REQ1_READY, 64'd0);
            cyc();
            n++;
        end
        check("latency", n, exp_lat);
        check("rsp_data", RSP_DATA, exp_data);
        check("rsp_id", RSP_ID, id);
        check("rsp_eq", RSP_EQ, exp_eq);
        check("rsp_err", RSP_ERR, exp_err);
        RSP_READY = 1'b1;
        cyc();
        RSP_READY = 1'b0;
        #1;
        check("rsp_drop", RSP_VALID, 64'd0);
    endtask

    initial begin
        REQ0_VALID = 0; REQ1_VALID = 0; RSP_READY = 0;
        REQ0_X = 0; REQ0_Y = 0; REQ0_OP = 0;
        REQ1_X = 0; REQ1_Y = 0; REQ1_OP = 0;
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        REQ0_VALID = 1'b1;
        #1;
        check("rst_rsp_valid", RSP_VALID, 64'd0);
        check("rst_alu_op", ALU_OP, 64'd0);
        check("rst_alu_x", ALU_X, 64'd0);
        check("rst_rsp_data", RSP_DATA, 64'd0);
        check("rst_ready0", REQ0_READY, 64'd0);
        REQ0_VALID = 1'b0;
        cyc(); cyc();
        RESET = 1'b0;
        #1;

        // Single-cycle ops and hold-time ops on each requester
        do_op(1'b0, 64'd5, 64'd7, 4'd0, 64'd12, 1'b0, 1'b0, 2);
        do_op(1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 4'd8, 64'd0, 1'b1, 1'b0, 5);
        do_op(1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 4'd9, 64'd1, 1'b1, 1'b0, 5);
        do_op(1'b0, 64'd10, 64'd0, 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 5);
        do_op(1'b0, 64'd10, 64'd0, 4'd11, 64'd10, 1'b0, 1'b0, 5);
        do_op(1'b1, 64'd100, 64'd7, 4'd10, 64'd14, 1'b0, 1'b0, 5);
        do_op(1'b0, 64'd1, 64'd2, 4'd15, 64'd0, 1'b0, 1'b1, 2);
        do_op(1'b1, 64'd7, 64'd7, 4'd14, 64'd0, 1'b1, 1'b1, 2);

        // Both requesters busy from reset: strict alternation starting with REQ0
        RESET = 1'b1;
        REQ0_VALID = 1; REQ0_X = 9; REQ0_Y = 4; REQ0_OP = 1;
        REQ1_VALID = 1; REQ1_X = 9; REQ1_Y = 4; REQ1_OP = 1;
        RSP_READY = 1'b1;
        cyc(); cyc();
        RESET = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_ready0", REQ0_READY, (k % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_ready1", REQ1_READY, (k % 2 == 1) ? 64'd1 : 64'd0);
            cyc();
            check("rr_exec_ready", REQ0_READY | REQ1_READY, 64'd0);
            cyc();
            check("rr_rsp_valid", RSP_VALID, 64'd1);
            check("rr_rsp_id", RSP_ID, (k % 2 == 1) ? 64'd1 : 64'd0);
            check("rr_rsp_data", RSP_DATA, 64'd5);
            check("rr_resp_ready", REQ0_READY | REQ1_READY, 64'd0);
            cyc();
        end
        REQ0_VALID = 0; REQ1_VALID = 0; RSP_READY = 0;
        #1;

        // Back-pressure: response held while a new request waits
        REQ0_VALID = 1; REQ0_X = 3; REQ0_Y = 3; REQ0_OP = 0;
        #1;
        check("bp_accept", REQ0_READY, 64'd1);
        cyc();
        REQ0_X = 9; REQ0_Y = 4; REQ0_OP = 1;
        cyc();
        for (int k = 0; k < 6; k++) begin
            check("bp_valid", RSP_VALID, 64'd1);
            check("bp_data", RSP_DATA, 64'd6);
            check("bp_eq", RSP_EQ, 64'd1);
            check("bp_id", RSP_ID, 64'd0);
            check("bp_ready", REQ0_READY, 64'd0);
            cyc();
        end
        RSP_READY = 1'b1;
        #1;
        check("bp_hs_ready", REQ0_READY, 64'd0);
        cyc();
        RSP_READY = 1'b0;
        #1;
        check("bp_drop", RSP_VALID, 64'd0);
        check("bp_regrant", REQ0_READY, 64'd1);
        cyc();
        REQ0_VALID = 1'b0;
        #1;
        check("bp_next_op", ALU_OP, 64'd1);
        cyc();
        check("bp_next_data", RSP_DATA, 64'd5);
        RSP_READY = 1'b1;
        cyc();
        RSP_READY = 1'b0;
        #1;

        // Reset in the middle of a REQ0 divide
        REQ0_VALID = 1; REQ0_X = 50; REQ0_Y = 5; REQ0_OP = 10;
        #1;
        check("mid_accept", REQ0_READY, 64'd1);
        cyc();
        REQ0_VALID = 1'b0;
        cyc();
        check("mid_alu_op", ALU_OP, 64'd10);
        RESET = 1'b1;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        #1;
        check("mid_rst_alu_op", ALU_OP, 64'd0);
        check("mid_rst_alu_x", ALU_X, 64'd0);
        check("mid_rst_alu_y", ALU_Y, 64'd0);
        check("mid_rst_valid", RSP_VALID, 64'd0);
        check("mid_rst_ready", REQ0_READY | REQ1_READY, 64'd0);
`ifdef ALU_ARB_PERF_EN
        check("perf_grant0", PERF_GRANT0, 64'd0);
        check("perf_grant1", PERF_GRANT1, 64'd0);
        check("perf_busy", PERF_BUSY, 64'd0);
`endif
        cyc(); cyc();
        RESET = 1'b0;
        #1;
        check("post_rst_ready0", REQ0_READY, 64'd1);
        check("post_rst_ready1", REQ1_READY, 64'd0);
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("no_phantom_rsp", RSP_VALID, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 64-bit ALU between two requesters (REQ0 = integer pipe, REQ1 = address/branch unit).
- Each request is a valid/ready handshake. Grants alternate round-robin, and the chosen operands and opcode are held steady on the ALU for a per-op number of cycles.
- The result is registered and returned on a single response channel tagged with the requester ID.
- Sits between the issue logic and the ALU; the ALU is instantiated beside it, not inside it.

Parameters:
- MULDIV_CYCLES, 4: hold cycles for OP 8–11 (mul, mulh, div, rem); legal range 1–15.
- XLEN, 64: operand and result width.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ0_VALID  input  1  requester 0 has an op.
- REQ0_READY  output  1  requester 0 op accepted this cycle.
- REQ0_X  input  XLEN  operand X.
- REQ0_Y  input  XLEN  operand Y.
- REQ0_OP  input  4  ALU opcode.
- REQ1_VALID, REQ1_READY, REQ1_X, REQ1_Y, REQ1_OP: same as requester 0.
- ALU_X  output  XLEN  to ALU.
- ALU_Y  output  XLEN  to ALU.
- ALU_OP  output  4  to ALU.
- ALU_RESULT  input  XLEN  from ALU.
- ALU_EQUAL  input  1  from ALU.
- RSP_VALID  output  1  response available.
- RSP_READY  input  1  consumer takes response.
- RSP_ID  output  1  requester that owns the response.
- RSP_DATA  output  XLEN  result.
- RSP_EQ  output  1  X==Y flag.
- RSP_ERR  output  1  illegal opcode.

Behaviour:
- Reset (async, immediate):
  - All outputs 0; FSM to IDLE.
  - LAST_GRANT=1, so REQ0 wins first.
  - An in-flight op is discarded and never responded to.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Picks among valid requesters. If both are valid, the winner is the one not equal to LAST_GRANT; otherwise the sole valid one.
  - REQx_READY is asserted combinationally only for the winner, only in IDLE. No READY in EXEC or RESP.
  - On the accepting edge: latch X, Y, OP and ID; set LAST_GRANT=ID; load the cycle counter; go to EXEC.
- Hold times:
  - Counter = MULDIV_CYCLES for OP 8–11.
  - Counter = 1 for OP 0–7, 12, 13.
  - OP 14/15: counter = 1, flagged illegal.
- EXEC:
  - ALU_X, ALU_Y, ALU_OP driven from latches and stable for the whole state.
  - The counter decrements each cycle.
  - On the edge where the counter reaches 1: capture ALU_RESULT into RSP_DATA and ALU_EQUAL into RSP_EQ, then go to RESP.
- Latency: accept edge T → RSP_VALID high from cycle T+1+hold; 2 cycles for single-cycle ops.
- Result overrides at capture, applied instead of ALU_RESULT:
  - OP 10 with Y==0: all-ones.
  - OP 11 with Y==0: X.
  - OP 14/15: RSP_DATA=0, RSP_ERR=1.
- RESP:
  - RSP_VALID held with stable RSP_ID/RSP_DATA/RSP_EQ/RSP_ERR until RSP_READY.
  - On the handshake edge: RSP_VALID drops, go to IDLE. No new accept in the same cycle; next grant one cycle later.
- ALU_* outputs in IDLE/RESP hold the last latched values (no toggling).
- REQ operands are sampled only on the accept edge; later changes are ignored.
- Requests that are not accepted are never dropped; the requester must hold VALID.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined: adds outputs PERF_GRANT0 (32), PERF_GRANT1 (32) and PERF_BUSY (32).
  - Grant counters increment on each accept for that ID.
  - PERF_BUSY increments every cycle the FSM is in EXEC.
  - All three are reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=0 … OP_SLTU=13;
  - a helper deciding whether an op is multi-cycle (OP 8–11);
  - the FSM state typedef {IDLE, EXEC, RESP};
  - XLEN default.
- One natural sub-module, rr_arb2: 2-input round-robin grant from VALIDs and LAST_GRANT. Purely combinational; LAST_GRANT register stays in alu_arbiter.

Test Plan:
- Reset then REQ0 ADD X=5, Y=7 → REQ0_READY at T; ALU_OP=0 in T+1; RSP_VALID at T+2 with DATA=12, ID=0, EQ=0, ERR=0.
- REQ0 and REQ1 both valid from reset, each with SUB 9-4, RSP_READY=1 → grant order 0,1,0,1; each response DATA=5; REQ1_READY never asserted while the FSM is busy.
- MULDIV_CYCLES=4, REQ1 MUL 0x1_0000_0000 × 0x1_0000_0000 → ALU_OP=8 stable 4 cycles; RSP at T+5 with DATA=0, ID=1. With MULH (OP 9) → DATA=1.
- DIV X=10, Y=0 → DATA=0xFFFF_FFFF_FFFF_FFFF; REM X=10, Y=0 → DATA=10; OP=15 → DATA=0, ERR=1 after 2 cycles.
- RSP_READY low for 6 cycles → RSP fields stable, no REQ_READY; RSP_READY high → IDLE next cycle, next grant one cycle later.
- RESET asserted mid-EXEC of a DIV → outputs 0 immediately, no response ever issued. After release, REQ0 wins first. With ALU_ARB_PERF_EN defined, counters read 0.
